// File: rtl/bomb_game_if.sv
// Signal bundle between the game sequencer and its surroundings: upstream
// button/switch pulses and the RAM controller's level come in, the state
// code, player ID, countdown and cut progress go out.
interface bomb_game_if;
    logic       tick;        // one-cycle 1 Hz enable
    logic       login;       // one-cycle pulse, samples id_sw
    logic [3:0] id_sw;       // player ID switches
    logic       start;       // one-cycle pulse, arms the bomb
    logic [3:0] cut;         // wire-cut pulses, one bit per wire
    logic [7:0] cur_level;   // player level from the RAM controller
    logic [7:0] game_state;  // state code consumed downstream
    logic [3:0] user_id;     // latched player ID
    logic [7:0] time_left;   // seconds remaining
    logic [3:0] step;        // correct cuts so far this level

    // Environment side: drives the pulses and the level, observes the game.
    modport master (
        output tick, login, id_sw, start, cut, cur_level,
        input  game_state, user_id, time_left, step
    );

    // Sequencer side.
    modport slave (
        input  tick, login, id_sw, start, cut, cur_level,
        output game_state, user_id, time_left, step
    );
endinterface

// File: rtl/bomb_game_fsm.sv
// Bomb-defusal game sequencer. Latches the player ID at login, arms a bomb
// whose countdown and cut count scale with the player's level, checks each
// wire cut against the required rotation and times out on the 1 Hz tick.
// All outputs are registered; state codes are driven directly on game_state.
module bomb_game_fsm #(
    parameter int BASE_TIME = 60,   // countdown seconds at level 0
    parameter int TIME_STEP = 4,    // seconds removed per level
    parameter int MIN_TIME  = 10,   // countdown floor
    parameter int MAX_STEPS = 8     // cap on cuts per level
) (
    input  logic        clk,
    input  logic        reset,      // synchronous, active-low
    bomb_game_if.slave  bus
);

    // Encodings equal the downstream state codes so the register can be
    // exported without a decode stage.
    typedef enum logic [7:0] {
        ST_IDLE     = 8'h00,
        ST_READY    = 8'h08,
        ST_ARMED    = 8'h10,
        ST_DEFUSED  = 8'h20,
        ST_LOAD     = 8'h30,
        ST_EXPLODED = 8'h40
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] user_id_q, user_id_d;
    logic [7:0] time_left_q, time_left_d;
    logic [3:0] step_q, step_d;
    logic [7:0] lvl_q, lvl_d;

    // ------------------------------------------------------------------
    // Login qualification: only IDs C..F are players.
    // ------------------------------------------------------------------
    logic valid_login;
    assign valid_login = bus.login && (bus.id_sw[3:2] == 2'b11);

    // ------------------------------------------------------------------
    // Countdown load value, evaluated on the live cur_level because it is
    // only used in the cycle that snapshots that level. Held at 16 bits so
    // a large level saturates at zero instead of wrapping before the floor.
    // ------------------------------------------------------------------
    localparam logic [15:0] BASE_TIME_W = 16'(BASE_TIME);
    localparam logic [15:0] TIME_STEP_W = 16'(TIME_STEP);
    localparam logic [15:0] MIN_TIME_W  = 16'(MIN_TIME);

    logic [15:0] lvl_penalty;
    logic [15:0] time_raw;
    logic [15:0] time_load;

    assign lvl_penalty = TIME_STEP_W * {8'd0, bus.cur_level};
    assign time_raw    = (lvl_penalty < BASE_TIME_W) ? (BASE_TIME_W - lvl_penalty) : 16'd0;
    assign time_load   = (time_raw > MIN_TIME_W) ? time_raw : MIN_TIME_W;

    // ------------------------------------------------------------------
    // Cut bookkeeping for the armed bomb.
    // ------------------------------------------------------------------
    localparam logic [8:0] MAX_STEPS_W = 9'(MAX_STEPS);

    logic [8:0] lvl_plus_one;
    logic [8:0] need;
    logic [3:0] step_inc;
    logic [1:0] wire_idx;
    logic [3:0] expected_cut;
    logic       cut_any;
    logic       cut_ok;
    logic       cut_bad;
    logic       cut_final;
    logic       timer_expire;

    assign lvl_plus_one = {1'b0, lvl_q} + 9'd1;
    assign need         = (lvl_plus_one > MAX_STEPS_W) ? MAX_STEPS_W : lvl_plus_one;
    assign step_inc     = step_q + 4'd1;

    // The required wire rotates through the four wires, offset by level;
    // mod 4 falls out of keeping only the low two bits of the sum.
    assign wire_idx = lvl_q[1:0] + step_q[1:0];

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_expected
            assign expected_cut[gi] = (wire_idx == 2'(gi));
        end
    endgenerate

    // Any cut pattern other than the exact one-hot wire (including several
    // wires at once) is fatal.
    assign cut_any      = |bus.cut;
    assign cut_ok       = (bus.cut == expected_cut);
    assign cut_bad      = cut_any && !cut_ok;
    assign cut_final    = cut_ok && ({5'd0, step_inc} == need);
    assign timer_expire = bus.tick && (time_left_q == 8'd1);

    // ------------------------------------------------------------------
    // State and datapath registers.
    // ------------------------------------------------------------------
    // Register update with synchronous active-low clear.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            user_id_q   <= 4'h0;
            time_left_q <= 8'h00;
            step_q      <= 4'h0;
            lvl_q       <= 8'h00;
        end else begin
            state_q     <= state_d;
            user_id_q   <= user_id_d;
            time_left_q <= time_left_d;
            step_q      <= step_d;
            lvl_q       <= lvl_d;
        end
    end

    // Next-state and datapath decisions; everything holds unless a branch
    // below says otherwise.
    always_comb begin
        state_d     = state_q;
        user_id_d   = user_id_q;
        time_left_d = time_left_q;
        step_d      = step_q;
        lvl_d       = lvl_q;

        unique case (state_q)
            ST_IDLE: begin
                if (valid_login) begin
                    user_id_d = bus.id_sw;
                    state_d   = ST_LOAD;
                end
            end

            ST_READY: begin
                // Login takes precedence so a player change never arms a
                // bomb with the previous player's level.
                if (valid_login) begin
                    user_id_d = bus.id_sw;
                    state_d   = ST_LOAD;
                end else if (bus.start) begin
                    lvl_d       = bus.cur_level;
                    step_d      = 4'h0;
                    time_left_d = time_load[7:0];
                    state_d     = ST_ARMED;
                end
            end

            ST_LOAD: begin
                // One cycle for the RAM controller to present cur_level.
                state_d = ST_READY;
            end

            ST_ARMED: begin
                // The countdown runs on every tick regardless of cuts; the
                // outcome below only decides where the state goes.
                if (bus.tick && (time_left_q != 8'd0)) begin
                    time_left_d = time_left_q - 8'd1;
                end

                if (cut_bad) begin
                    state_d = ST_EXPLODED;
                end else if (cut_ok) begin
                    step_d = step_inc;
                    if (cut_final) begin
                        // A finishing cut beats a simultaneous expiry.
                        state_d = ST_DEFUSED;
                    end else if (timer_expire) begin
                        state_d = ST_EXPLODED;
                    end
                end else if (timer_expire) begin
                    state_d = ST_EXPLODED;
                end
            end

            ST_DEFUSED: begin
                // Single-cycle pulse so downstream bumps the level once.
                state_d = ST_READY;
            end

            ST_EXPLODED: begin
                // start only returns to READY; a second start is needed to
                // arm again.
                if (valid_login) begin
                    user_id_d = bus.id_sw;
                    state_d   = ST_LOAD;
                end else if (bus.start) begin
                    state_d = ST_READY;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.game_state = state_q;
    assign bus.user_id    = user_id_q;
    assign bus.time_left  = time_left_q;
    assign bus.step       = step_q;

endmodule

// File: tb/tb_bomb_game_fsm.sv
// Self-checking bench for bomb_game_fsm: a directed vector table, a few
// hand-written multi-cycle sequences, then random stimulus against a
// behavioural model of the game rules.
module tb_bomb_game_fsm;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    always #5 clk = ~clk;

    bomb_game_if bus ();

    bomb_game_fsm #(
        .BASE_TIME (60),
        .TIME_STEP (4),
        .MIN_TIME  (10),
        .MAX_STEPS (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int passes = 0;

    typedef struct {
        logic       r;
        logic       l;
        logic [3:0] id;
        logic       s;
        logic [3:0] c;
        logic       t;
        logic [7:0] lv;
        logic [7:0] st;
        logic [3:0] uid;
        logic [7:0] tm;
        logic [3:0] sp;
    } vec_t;

    localparam int NVEC = 27;
    vec_t vecs [NVEC];

    function automatic vec_t mk(input logic r, input logic l, input logic [3:0] id,
                                input logic s, input logic [3:0] c, input logic t,
                                input logic [7:0] lv, input logic [7:0] st,
                                input logic [3:0] uid, input logic [7:0] tm,
                                input logic [3:0] sp);
        vec_t v;
        v.r = r; v.l = l; v.id = id; v.s = s; v.c = c; v.t = t; v.lv = lv;
        v.st = st; v.uid = uid; v.tm = tm; v.sp = sp;
        return v;
    endfunction

    // Apply one cycle of inputs at the falling edge, then settle past the
    // next rising edge so outputs are sampled away from it.
    task automatic drive(input logic r, input logic l, input logic [3:0] id,
                         input logic s, input logic [3:0] c, input logic t,
                         input logic [7:0] lv);
        @(negedge clk);
        reset         = r;
        bus.login     = l;
        bus.id_sw     = id;
        bus.start     = s;
        bus.cut       = c;
        bus.tick      = t;
        bus.cur_level = lv;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string name, input logic [7:0] st,
                              input logic [3:0] uid, input logic [7:0] tm,
                              input logic [3:0] sp);
        checks++;
        if (bus.game_state === st && bus.user_id === uid &&
            bus.time_left === tm && bus.step === sp) begin
            passes++;
        end else begin
            $display("FAIL %s: got state=%h uid=%h time=%0d step=%0d, want state=%h uid=%h time=%0d step=%0d",
                     name, bus.game_state, bus.user_id, bus.time_left, bus.step,
                     st, uid, tm, sp);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: game rules in plain integer arithmetic.
    // ------------------------------------------------------------------
    localparam int M_IDLE = 8'h00, M_READY = 8'h08, M_ARMED = 8'h10,
                   M_DEF  = 8'h20, M_LOAD  = 8'h30, M_EXP   = 8'h40;

    int m_st, m_uid, m_tm, m_sp, m_lvl;

    function automatic int wire_for(input int lvl, input int stp);
        return 1 << ((lvl + stp) % 4);
    endfunction

    task automatic model_step(input bit r, input bit l, input int id, input bit s,
                              input int c, input bit t, input int lv);
        int need;
        bit expiring;
        if (!r) begin
            m_st = M_IDLE; m_uid = 0; m_tm = 0; m_sp = 0; m_lvl = 0;
            return;
        end
        if (m_st == M_IDLE || m_st == M_READY || m_st == M_EXP) begin
            if (l && id >= 12) begin
                m_uid = id;
                m_st  = M_LOAD;
            end else if (s && m_st == M_READY) begin
                m_lvl = lv;
                m_sp  = 0;
                m_tm  = 60 - 4 * lv;
                if (m_tm < 10) m_tm = 10;
                m_st  = M_ARMED;
            end else if (s && m_st == M_EXP) begin
                m_st = M_READY;
            end
        end else if (m_st == M_LOAD || m_st == M_DEF) begin
            m_st = M_READY;
        end else begin
            need     = (m_lvl + 1 < 8) ? m_lvl + 1 : 8;
            expiring = t && (m_tm == 1);
            if (t && m_tm > 0) m_tm--;
            if (c == 0) begin
                if (expiring) m_st = M_EXP;
            end else if (c == wire_for(m_lvl, m_sp)) begin
                m_sp++;
                if (m_sp == need) m_st = M_DEF;
                else if (expiring) m_st = M_EXP;
            end else begin
                m_st = M_EXP;
            end
        end
    endtask

    initial begin
        bus.login = 1'b0; bus.id_sw = 4'h0; bus.start = 1'b0;
        bus.cut = 4'h0; bus.tick = 1'b0; bus.cur_level = 8'h00;

        //                r  l  id     s  cut    t  lvl     state  uid    time    step
        vecs[0]  = mk(0, 0, 4'h0, 0, 4'h0, 0, 8'd0,   8'h00, 4'h0, 8'd0,  4'd0);
        vecs[1]  = mk(1, 1, 4'h3, 0, 4'h0, 0, 8'd0,   8'h00, 4'h0, 8'd0,  4'd0);
        vecs[2]  = mk(1, 1, 4'hC, 0, 4'h0, 0, 8'd0,   8'h30, 4'hC, 8'd0,  4'd0);
        vecs[3]  = mk(1, 0, 4'h0, 0, 4'h0, 0, 8'd2,   8'h08, 4'hC, 8'd0,  4'd0);
        vecs[4]  = mk(1, 0, 4'h0, 1, 4'h0, 0, 8'd2,   8'h10, 4'hC, 8'd52, 4'd0);
        vecs[5]  = mk(1, 0, 4'h0, 0, 4'h4, 0, 8'd2,   8'h10, 4'hC, 8'd52, 4'd1);
        vecs[6]  = mk(1, 0, 4'h0, 0, 4'h8, 0, 8'd2,   8'h10, 4'hC, 8'd52, 4'd2);
        vecs[7]  = mk(1, 0, 4'h0, 0, 4'h1, 0, 8'd2,   8'h20, 4'hC, 8'd52, 4'd3);
        vecs[8]  = mk(1, 0, 4'h0, 0, 4'h0, 0, 8'd0,   8'h08, 4'hC, 8'd52, 4'd3);
        vecs[9]  = mk(1, 0, 4'h0, 1, 4'h0, 0, 8'd0,   8'h10, 4'hC, 8'd60, 4'd0);
        vecs[10] = mk(1, 0, 4'h0, 0, 4'h2, 0, 8'd0,   8'h40, 4'hC, 8'd60, 4'd0);
        vecs[11] = mk(1, 0, 4'h0, 1, 4'h0, 0, 8'd0,   8'h08, 4'hC, 8'd60, 4'd0);
        vecs[12] = mk(1, 0, 4'h0, 1, 4'h0, 0, 8'd0,   8'h10, 4'hC, 8'd60, 4'd0);
        vecs[13] = mk(1, 0, 4'h0, 0, 4'h3, 0, 8'd0,   8'h40, 4'hC, 8'd60, 4'd0);
        vecs[14] = mk(1, 0, 4'h0, 1, 4'h0, 0, 8'd0,   8'h08, 4'hC, 8'd60, 4'd0);
        vecs[15] = mk(1, 0, 4'h0, 1, 4'h0, 0, 8'd0,   8'h10, 4'hC, 8'd60, 4'd0);
        vecs[16] = mk(1, 0, 4'h0, 0, 4'h0, 1, 8'd0,   8'h10, 4'hC, 8'd59, 4'd0);
        vecs[17] = mk(1, 0, 4'h0, 1, 4'h0, 1, 8'd0,   8'h10, 4'hC, 8'd58, 4'd0);
        vecs[18] = mk(1, 1, 4'hD, 0, 4'h0, 0, 8'd0,   8'h10, 4'hC, 8'd58, 4'd0);
        vecs[19] = mk(0, 0, 4'h0, 0, 4'h0, 0, 8'd0,   8'h00, 4'h0, 8'd0,  4'd0);
        vecs[20] = mk(1, 1, 4'hF, 0, 4'h0, 0, 8'd0,   8'h30, 4'hF, 8'd0,  4'd0);
        vecs[21] = mk(1, 0, 4'h0, 0, 4'h0, 0, 8'd255, 8'h08, 4'hF, 8'd0,  4'd0);
        vecs[22] = mk(1, 0, 4'h0, 1, 4'h0, 1, 8'd255, 8'h10, 4'hF, 8'd10, 4'd0);
        vecs[23] = mk(0, 0, 4'h0, 0, 4'h0, 0, 8'd0,   8'h00, 4'h0, 8'd0,  4'd0);
        vecs[24] = mk(1, 1, 4'hE, 0, 4'h0, 0, 8'd0,   8'h30, 4'hE, 8'd0,  4'd0);
        vecs[25] = mk(1, 0, 4'h0, 0, 4'h0, 0, 8'd20,  8'h08, 4'hE, 8'd0,  4'd0);
        vecs[26] = mk(1, 0, 4'h0, 1, 4'h0, 0, 8'd20,  8'h10, 4'hE, 8'd10, 4'd0);

        for (int i = 0; i < NVEC; i++) begin
            drive(vecs[i].r, vecs[i].l, vecs[i].id, vecs[i].s, vecs[i].c,
                  vecs[i].t, vecs[i].lv);
            expect_out($sformatf("vec%0d", i), vecs[i].st, vecs[i].uid,
                       vecs[i].tm, vecs[i].sp);
        end

        // Timeout at the floor: ten ticks, explosion on the 1 -> 0 edge.
        for (int k = 1; k <= 9; k++) begin
            drive(1, 0, 4'h0, 0, 4'h0, 1, 8'd20);
            expect_out($sformatf("timeout_tick%0d", k), 8'h10, 4'hE, 8'(10 - k), 4'd0);
        end
        drive(1, 0, 4'h0, 0, 4'h0, 1, 8'd20);
        expect_out("timeout_expire", 8'h40, 4'hE, 8'd0, 4'd0);

        // Level 0 with one second left: the finishing cut beats the expiry.
        drive(1, 0, 4'h0, 1, 4'h0, 0, 8'd0);
        expect_out("exploded_start", 8'h08, 4'hE, 8'd0, 4'd0);
        drive(1, 0, 4'h0, 1, 4'h0, 0, 8'd0);
        expect_out("arm_lvl0", 8'h10, 4'hE, 8'd60, 4'd0);
        for (int k = 1; k <= 59; k++) drive(1, 0, 4'h0, 0, 4'h0, 1, 8'd0);
        expect_out("lvl0_one_left", 8'h10, 4'hE, 8'd1, 4'd0);
        drive(1, 0, 4'h0, 0, 4'h1, 1, 8'd0);
        expect_out("final_cut_with_expiry", 8'h20, 4'hE, 8'd0, 4'd1);
        drive(1, 0, 4'h0, 0, 4'h0, 0, 8'd1);
        expect_out("defused_to_ready", 8'h08, 4'hE, 8'd0, 4'd1);

        // Level 1 with one second left: a non-final cut cannot save it.
        drive(1, 0, 4'h0, 1, 4'h0, 0, 8'd1);
        expect_out("arm_lvl1", 8'h10, 4'hE, 8'd56, 4'd0);
        for (int k = 1; k <= 55; k++) drive(1, 0, 4'h0, 0, 4'h0, 1, 8'd1);
        expect_out("lvl1_one_left", 8'h10, 4'hE, 8'd1, 4'd0);
        drive(1, 0, 4'h0, 0, 4'h2, 1, 8'd1);
        expect_out("nonfinal_cut_with_expiry", 8'h40, 4'hE, 8'd0, 4'd1);
        drive(1, 1, 4'hC, 0, 4'h0, 0, 8'd1);
        expect_out("exploded_login", 8'h30, 4'hC, 8'd0, 4'd1);

        // Random play against the model.
        for (int i = 0; i < 3000; i++) begin
            bit r, l, s, t;
            int id, c, lv, sel;
            r   = (i == 0) ? 1'b0 : ($urandom_range(0, 199) != 0);
            l   = ($urandom_range(0, 19) == 0);
            id  = $urandom_range(0, 15);
            s   = ($urandom_range(0, 5) == 0);
            t   = ($urandom_range(0, 2) == 0);
            lv  = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 10);
            sel = $urandom_range(0, 9);
            if (sel < 5)      c = 0;
            else if (sel < 9) c = wire_for(m_lvl, m_sp);
            else              c = $urandom_range(1, 15);
            drive(r, l, 4'(id), s, 4'(c), t, 8'(lv));
            model_step(r, l, id, s, c, t, lv);
            expect_out($sformatf("rand%0d", i), 8'(m_st), 4'(m_uid), 8'(m_tm), 4'(m_sp));
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/bomb_game_fsm.md
# bomb_game_fsm

Top-level game sequencer for the bomb-defusal game. It latches the player ID at login, arms a bomb whose difficulty scales with the player's current level, and checks wire cuts against the required order under a countdown. It produces the `game_state` code and `user_id` consumed by the downstream RAM controller, and takes back that controller's `cur_level`.

## Interface
- `BASE_TIME`, 60: countdown seconds at level 0
- `TIME_STEP`, 4: seconds removed per level
- `MIN_TIME`, 10: countdown floor
- `MAX_STEPS`, 8: cap on cuts per level

- `clk`  in  1  system clock
- `reset`  in  1  synchronous, active-low
- `tick`  in  1  one-cycle 1 Hz enable
- `login`  in  1  one-cycle pulse; samples `id_sw`
- `id_sw`  in  4  player ID switches
- `start`  in  1  one-cycle pulse; arms the bomb
- `cut`  in  4  wire-cut pulses, one bit per wire
- `cur_level`  in  8  player level from the RAM controller
- `game_state`  out  8  state code (see Operation)
- `user_id`  out  4  latched player ID
- `time_left`  out  8  seconds remaining
- `step`  out  4  correct cuts so far this level

## Operation
- State codes driven on `game_state`:
  - IDLE = 8'h00
  - READY = 8'h08
  - ARMED = 8'h10
  - DEFUSED = 8'h20
  - LOAD = 8'h30
  - EXPLODED = 8'h40
- Valid IDs are 4'hC–4'hF. A `login` carrying any other ID is ignored, with no state change.
- IDLE / READY / EXPLODED:
  - A valid `login` latches `user_id` and moves to LOAD.
- LOAD:
  - Lasts exactly 1 cycle, then moves to READY.
  - The downstream block uses it to fetch the level into `cur_level`.
- READY:
  - `start` snapshots `cur_level` into an internal `lvl` and clears `step`.
  - It also loads `time_left` = max(BASE_TIME − TIME_STEP·lvl, MIN_TIME), computed at 16 bits so the subtraction cannot underflow, then truncated to 8 bits.
  - Then moves to ARMED.
  - `start` in any other state is ignored.
- ARMED:
  - Required cuts: `need` = min(lvl+1, MAX_STEPS).
  - Expected wire: one-hot `1 << ((lvl + step) mod 4)`.
  - `cut == expected`: `step` increments. If `step+1 == need`, move to DEFUSED.
  - `cut` nonzero and not equal to expected (this includes multi-bit cuts): move to EXPLODED.
  - `tick`: `time_left` decrements. If `time_left == 1`, it becomes 0 and the state moves to EXPLODED.
  - `login` is ignored.
- DEFUSED:
  - Lasts exactly 1 cycle, then moves to READY.
  - `user_id` is held.
  - Downstream increments the stored level once per DEFUSED cycle.
- EXPLODED:
  - Held until a valid `login` (moves to LOAD) or `start`.
  - `start` here moves to READY and does not arm; the next `start` arms.
- Simultaneous events in ARMED:
  - A correct final cut together with an expiring `tick` goes to DEFUSED; the cut wins.
  - A wrong cut together with any `tick` goes to EXPLODED.
  - A correct non-final cut together with an expiring `tick` goes to EXPLODED.
- Reset (`reset == 0` at a clock edge), from any state including mid-ARMED:
  - `game_state` = 8'h00
  - `user_id` = 4'h0
  - `time_left` = 8'h00
  - `step` = 4'h0
  - `lvl` = 0
- `time_left` and `step` hold their values outside ARMED, except where they are reloaded at `start`.

## Timing
- All outputs are registered and change only on `clk` rising edges.
- Input pulses are sampled at a rising edge. The response appears on outputs after that edge (1-cycle latency).
- `login` → LOAD: 1 cycle. LOAD → READY: 1 cycle. `cur_level` must be valid by the READY cycle in which `start` is sampled.
- DEFUSED is visible for exactly 1 cycle, and READY follows on the next cycle.
- A `tick` that arrives in the same cycle as `start` is not applied; counting begins on the first `tick` sampled while in ARMED.
- Inputs wider than one cycle are treated as repeated events. Debouncing and edge detection are done upstream.

## Test plan
- Reset mid-ARMED: force `reset = 0` → next edge shows `game_state` 00, `user_id` 0, `time_left` 0, `step` 0.
- Invalid login: `id_sw = 4'h3` with `login` in IDLE → stays at 00 and `user_id` stays 0. Then `id_sw = 4'hC` with `login` → 30 for one cycle, then 08, with `user_id = C`.
- Level-2 defuse: `cur_level = 2`, `start` → `time_left = 52`. Cuts 4'b0100, 4'b1000, 4'b0001 → `step` 1, 2, then 20 for one cycle, then 08.
- Wrong and multi-bit cuts: `cur_level = 0`. Cut 4'b0010 → 40. Re-arm and cut 4'b0011 → 40. Then `start` → 08.
- Timeout and floor: `cur_level = 20` → `time_left = 10`. Ten `tick`s with no cuts → 40 on the edge where `time_left` goes 1 → 0. Also check `cur_level = 255` → `time_left = 10`, with no underflow.
- Simultaneous events at `cur_level = 0`, `time_left = 1`:
  - Correct cut 4'b0001 with `tick` → 20.
  - At level 1, first correct cut with an expiring `tick` → 40.
